// File: rtl/display_hex_scheduler.sv
// rtl/display_hex_scheduler.sv - two-digit display sequencer: seconds counter, overlay arbiter, output mux
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_start / i_stop         pulses: clear seconds and run / clear seconds and idle (stop wins)
//   i_pause                  level: freeze the seconds count while high
//   i_speed_valid, i_speed   pulse + 4-bit speed shown as an overlay
//   i_vol_valid, i_vol       pulse + 6-bit volume shown as an overlay
//   o_hex                    registered value 0..MAX_SEC for the hex decoder
//   o_src                    0 seconds, 1 speed overlay, 2 volume overlay
//   o_blank                  force decoder dark (pause blink when PAUSE_BLINK_EN is defined)
//   o_done                   one-cycle pulse, aligned with o_hex first showing MAX_SEC
// Optional: define PAUSE_BLINK_EN to blink the display while paused.
module display_hex_scheduler #(
   parameter int TICK_CYCLES    = 12000000,
   parameter int OVERLAY_CYCLES = 18000000,
   parameter int MAX_SEC        = 35
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic       i_pause,
   input  logic       i_speed_valid,
   input  logic [3:0] i_speed,
   input  logic       i_vol_valid,
   input  logic [5:0] i_vol,
   output logic [5:0] o_hex,
   output logic [1:0] o_src,
   output logic       o_blank,
   output logic       o_done
);

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int HW = (OVERLAY_CYCLES > 1) ? $clog2(OVERLAY_CYCLES) : 1;
   localparam logic [5:0]    MAX_V     = 6'(MAX_SEC);
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(OVERLAY_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} main_e;
   typedef enum logic [1:0] {OV_NONE, OV_SPEED, OV_VOL} ov_e;

   main_e         main_q, main_d;
   logic [5:0]    sec_q, sec_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          hit_q, hit_d;
   ov_e           ov_q, ov_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [5:0]    ov_val_q, ov_val_d;
   logic [5:0]    hex_q, hex_d;
   logic [1:0]    src_q, src_d;
   logic          done_q, done_d;
   logic [5:0]    spd_ext, spd_clamp, vol_clamp;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         main_q   <= ST_IDLE;
         sec_q    <= '0;
         presc_q  <= '0;
         hit_q    <= 1'b0;
         ov_q     <= OV_NONE;
         hold_q   <= '0;
         ov_val_q <= '0;
         hex_q    <= '0;
         src_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         main_q   <= main_d;
         sec_q    <= sec_d;
         presc_q  <= presc_d;
         hit_q    <= hit_d;
         ov_q     <= ov_d;
         hold_q   <= hold_d;
         ov_val_q <= ov_val_d;
         hex_q    <= hex_d;
         src_q    <= src_d;
         done_q   <= done_d;
      end
   end

   // Main FSM. Counting is gated by the i_pause level itself, so the cycle
   // that enters PAUSE already freezes and the release cycle already counts.
   always_comb begin
      main_d  = main_q;
      sec_d   = sec_q;
      presc_d = presc_q;
      hit_d   = 1'b0;
      if (i_stop) begin
         main_d  = ST_IDLE;
         sec_d   = '0;
         presc_d = '0;
      end else if (i_start) begin
         main_d  = ST_RUN;
         sec_d   = '0;
         presc_d = '0;
      end else begin
         case (main_q)
            ST_IDLE: begin
               sec_d   = '0;
               presc_d = '0;
            end
            ST_RUN, ST_PAUSE: begin
               main_d = i_pause ? ST_PAUSE : ST_RUN;
               if (!i_pause) begin
                  if (presc_q == PRE_LAST) begin
                     presc_d = '0;
                     if (sec_q + 6'd1 >= MAX_V) begin
                        sec_d  = MAX_V;
                        main_d = ST_DONE;
                        hit_d  = 1'b1;
                     end else begin
                        sec_d = sec_q + 6'd1;
                     end
                  end else begin
                     presc_d = presc_q + PW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Overlay arbiter: speed beats volume, any request restarts the hold.
   always_comb begin
      spd_ext   = {2'b00, i_speed};
      spd_clamp = (spd_ext > MAX_V) ? MAX_V : spd_ext;
      vol_clamp = (i_vol > MAX_V) ? MAX_V : i_vol;
      ov_d      = ov_q;
      hold_d    = hold_q;
      ov_val_d  = ov_val_q;
      if (i_speed_valid) begin
         ov_d     = OV_SPEED;
         ov_val_d = spd_clamp;
         hold_d   = HOLD_LOAD;
      end else if (i_vol_valid) begin
         ov_d     = OV_VOL;
         ov_val_d = vol_clamp;
         hold_d   = HOLD_LOAD;
      end else if (ov_q != OV_NONE) begin
         if (hold_q == '0) begin
            ov_d = OV_NONE;
         end else begin
            hold_d = hold_q - HW'(1);
         end
      end
   end

   // Output stage; o_done is delayed one stage so it lines up with o_hex.
   always_comb begin
      hex_d  = sec_q;
      src_d  = 2'd0;
      done_d = hit_q;
      if (ov_q == OV_SPEED) begin
         hex_d = ov_val_q;
         src_d = 2'd1;
      end else if (ov_q == OV_VOL) begin
         hex_d = ov_val_q;
         src_d = 2'd2;
      end
   end

   assign o_hex  = hex_q;
   assign o_src  = src_q;
   assign o_done = done_q;

`ifdef PAUSE_BLINK_EN
   localparam int HALF = (TICK_CYCLES / 2 > 1) ? TICK_CYCLES / 2 : 1;
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          blank_q, blank_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bcnt_q  <= '0;
         blank_q <= 1'b0;
      end else begin
         bcnt_q  <= bcnt_d;
         blank_q <= blank_d;
      end
   end

   // Any exit from the paused/no-overlay condition restarts the pattern dark-off.
   always_comb begin
      bcnt_d  = '0;
      blank_d = 1'b0;
      if (main_q == ST_PAUSE && ov_q == OV_NONE) begin
         if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            blank_d = ~blank_q;
         end else begin
            bcnt_d  = bcnt_q + BW'(1);
            blank_d = blank_q;
         end
      end
   end

   assign o_blank = blank_q;
`else
   assign o_blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_hex_scheduler.sv
// tb/tb_display_hex_scheduler.sv - scoreboard bench for display_hex_scheduler
module tb_display_hex_scheduler;

   localparam int TICK = 4;
   localparam int OVL  = 6;
   localparam int MAXS = 35;
   localparam int HALF = TICK / 2;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_start, i_stop, i_pause;
   logic       i_speed_valid, i_vol_valid;
   logic [3:0] i_speed;
   logic [5:0] i_vol;
   logic [5:0] o_hex;
   logic [1:0] o_src;
   logic       o_blank, o_done;

   always #5 i_clk = ~i_clk;

   display_hex_scheduler #(
      .TICK_CYCLES(TICK),
      .OVERLAY_CYCLES(OVL),
      .MAX_SEC(MAXS)
   ) dut (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_start(i_start),
      .i_stop(i_stop),
      .i_pause(i_pause),
      .i_speed_valid(i_speed_valid),
      .i_speed(i_speed),
      .i_vol_valid(i_vol_valid),
      .i_vol(i_vol),
      .o_hex(o_hex),
      .o_src(o_src),
      .o_blank(o_blank),
      .o_done(o_done)
   );

   logic [9:0] exp_q[$];
   logic [9:0] mon_e;
   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: elapsed counted cycles -> seconds by division,
   // overlay as a remaining-visible-cycles budget.
   int m_mode;      // 0 idle, 1 counting (run or pause), 2 done
   int m_ticks;
   bit m_paused;
   bit m_done_ev;
   int m_ov_src;
   int m_ov_left;
   int m_ov_val;
   int m_plen;
   bit m_blink;

   task automatic model_reset();
      m_mode = 0; m_ticks = 0; m_paused = 0; m_done_ev = 0;
      m_ov_src = 0; m_ov_left = 0; m_ov_val = 0; m_plen = 0; m_blink = 0;
   endtask

   task automatic model_edge();
      int sec, e_hex, e_src;
      bit e_done, e_blank;
      sec = (m_mode == 0) ? 0 : ((m_ticks / TICK > MAXS) ? MAXS : m_ticks / TICK);
      if (m_ov_left > 0) begin
         e_hex = m_ov_val; e_src = m_ov_src;
      end else begin
         e_hex = sec; e_src = 0;
      end
      e_done = m_done_ev;
`ifdef PAUSE_BLINK_EN
      if (m_paused && m_ov_left == 0) begin
         m_plen++;
         m_blink = ((m_plen / HALF) % 2) == 1;
      end else begin
         m_plen = 0;
         m_blink = 0;
      end
      e_blank = m_blink;
`else
      e_blank = 0;
`endif
      exp_q.push_back({6'(e_hex), 2'(e_src), e_blank, e_done});

      m_done_ev = 0;
      if (i_stop) begin
         m_mode = 0; m_ticks = 0; m_paused = 0;
      end else if (i_start) begin
         m_mode = 1; m_ticks = 0; m_paused = 0;
      end else if (m_mode == 1) begin
         if (!i_pause) begin
            m_ticks++;
            if (m_ticks == MAXS * TICK) begin
               m_mode = 2;
               m_done_ev = 1;
            end
         end
         m_paused = i_pause;
      end else begin
         m_paused = 0;
      end

      if (i_speed_valid) begin
         m_ov_src = 1; m_ov_val = (int'(i_speed) > MAXS) ? MAXS : int'(i_speed); m_ov_left = OVL;
      end else if (i_vol_valid) begin
         m_ov_src = 2; m_ov_val = (int'(i_vol) > MAXS) ? MAXS : int'(i_vol); m_ov_left = OVL;
      end else if (m_ov_left > 0) begin
         m_ov_left--;
      end
   endtask

   task automatic step(input bit st, input bit sp, input bit pa, input bit svv,
                       input logic [3:0] s, input bit vvv, input logic [5:0] v);
      @(negedge i_clk);
      i_start = st; i_stop = sp; i_pause = pa;
      i_speed_valid = svv; i_speed = s;
      i_vol_valid = vvv; i_vol = v;
      model_edge();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 4'd0, 0, 6'd0);
   endtask

   task automatic chk(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // Monitor: every clock edge the DUT presents a new output word.
   initial begin
      forever begin
         @(posedge i_clk);
         cyc++;
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if ({o_hex, o_src, o_blank, o_done} !== mon_e) begin
               n_fail++;
               $display("FAIL scoreboard cyc=%0d: got hex=%0d src=%0d blank=%0d done=%0d expected hex=%0d src=%0d blank=%0d done=%0d",
                        cyc, o_hex, o_src, o_blank, o_done,
                        mon_e[9:4], mon_e[3:2], mon_e[1], mon_e[0]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit pz;
      i_rst_n = 1'b0;
      i_start = 0; i_stop = 0; i_pause = 0;
      i_speed_valid = 0; i_speed = '0; i_vol_valid = 0; i_vol = '0;
      model_reset();
      repeat (3) @(posedge i_clk);
      #2;
      chk("reset_hex", int'(o_hex), 0);
      chk("reset_src", int'(o_src), 0);
      chk("reset_blank", int'(o_blank), 0);
      chk("reset_done", int'(o_done), 0);
      i_rst_n = 1'b1;

      // start and count
      step(1, 0, 0, 0, 4'd0, 0, 6'd0);
      repeat (12) idle();
      @(posedge i_clk); #2;
      chk("run_sec_after_11", int'(o_hex), 2);

      // run to saturation and hold
      repeat (160) idle();
      @(posedge i_clk); #2;
      chk("saturated_hex", int'(o_hex), MAXS);
      step(1, 0, 0, 0, 4'd0, 0, 6'd0);
      idle();
      idle();
      @(posedge i_clk); #2;
      chk("restart_hex", int'(o_hex), 0);

      // prescaler now 2: pause 10 cycles then release
      repeat (10) step(0, 0, 1, 0, 4'd0, 0, 6'd0);
      repeat (6) idle();

      // volume clamp, speed-over-volume, re-request
      step(0, 0, 0, 0, 4'd0, 1, 6'd50);
      idle();
      @(posedge i_clk); #2;
      chk("vol_clamp_hex", int'(o_hex), MAXS);
      chk("vol_src", int'(o_src), 2);
      repeat (8) idle();
      step(0, 0, 0, 1, 4'd7, 1, 6'd20);
      idle();
      @(posedge i_clk); #2;
      chk("speed_wins_hex", int'(o_hex), 7);
      chk("speed_wins_src", int'(o_src), 1);
      repeat (2) idle();
      step(0, 0, 0, 0, 4'd0, 1, 6'd9);
      repeat (9) idle();

      // start and stop together
      step(1, 1, 0, 0, 4'd0, 0, 6'd0);
      repeat (3) idle();
      @(posedge i_clk); #2;
      chk("start_stop_hex", int'(o_hex), 0);

      // asynchronous reset mid-run with overlay shown
      step(1, 0, 0, 0, 4'd0, 0, 6'd0);
      repeat (5) idle();
      step(0, 0, 0, 0, 4'd0, 1, 6'd12);
      repeat (2) idle();
      @(posedge i_clk); #2;
      i_rst_n = 1'b0;
      #1;
      chk("async_reset_hex", int'(o_hex), 0);
      chk("async_reset_src", int'(o_src), 0);
      chk("async_reset_blank", int'(o_blank), 0);
      chk("async_reset_done", int'(o_done), 0);
      chk("queue_drained_at_reset", exp_q.size(), 0);
      model_reset();
      #1;
      i_rst_n = 1'b1;

      // pause with volume request in the middle
      step(1, 0, 0, 0, 4'd0, 0, 6'd0);
      repeat (3) idle();
      repeat (8) step(0, 0, 1, 0, 4'd0, 0, 6'd0);
      step(0, 0, 1, 0, 4'd0, 1, 6'd20);
      repeat (10) step(0, 0, 1, 0, 4'd0, 0, 6'd0);
      repeat (3) idle();

      // randomized traffic
      pz = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) pz = ~pz;
         step($urandom_range(149) == 0, $urandom_range(249) == 0, pz,
              $urandom_range(29) == 0, 4'($urandom),
              $urandom_range(29) == 0, 6'($urandom));
      end
      idle();
      repeat (2) @(posedge i_clk);
      #3;
      chk("queue_drained_at_end", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/display_hex_scheduler.md
Name: display_hex_scheduler

Overview:
- Sequences the two-digit 7-segment display path of the audio player.
- Owns the elapsed-seconds counter for play/record.
- Arbitrates temporary overlays (speed, volume) against the seconds readout.
- Drives the 6-bit value (0..35) consumed by the hex-to-two-digit decoder. Sits between the player control FSM and the decoder.

Parameters:
TICK_CYCLES, 12000000, i_clk cycles per displayed second (12 MHz audio clock).
OVERLAY_CYCLES, 18000000, cycles an overlay value stays on the display after its request.
MAX_SEC, 35, largest displayable count; seconds saturate here, overlay values clamp here.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  pulse: clear seconds, begin counting
i_stop  in  1  pulse: clear seconds, go idle
i_pause  in  1  level: freeze counting while high
i_speed_valid  in  1  pulse: show i_speed as overlay
i_speed  in  4  speed setting
i_vol_valid  in  1  pulse: show i_vol as overlay
i_vol  in  6  volume setting
o_hex  out  6  value to decoder, registered
o_src  out  2  0 = seconds, 1 = speed overlay, 2 = volume overlay
o_blank  out  1  high = decoder output should be forced dark
o_done  out  1  one-cycle pulse when seconds saturate at MAX_SEC

Behaviour:
- Reset (async, i_rst_n low): state IDLE, seconds 0, prescaler 0, overlay none, hold 0. Outputs: o_hex 0, o_src 0, o_blank 0, o_done 0.
- Main FSM states: IDLE, RUN, PAUSE, DONE.
  - i_stop in any state -> IDLE; seconds and prescaler cleared.
  - i_start in any state -> RUN; seconds and prescaler cleared.
  - i_start and i_stop in the same cycle -> i_stop wins.
  - RUN with i_pause high -> PAUSE. PAUSE with i_pause low -> RUN. Prescaler holds its value in PAUSE; no partial-second loss.
  - RUN: prescaler counts 0..TICK_CYCLES-1. On wrap, seconds increments.
  - A tick that takes seconds to MAX_SEC moves the FSM to DONE and pulses o_done for one cycle, registered with the seconds update.
  - DONE holds seconds at MAX_SEC; i_pause is ignored. Only i_start or i_stop leaves DONE.
  - IDLE: prescaler and seconds stay 0.
- Overlay arbiter states: NONE, SPEED, VOL.
  - Each accepted request loads the hold counter with OVERLAY_CYCLES-1 and latches the value, clamped to MAX_SEC (speed is zero-extended).
  - If i_speed_valid and i_vol_valid arrive in the same cycle, speed wins and the volume request is dropped.
  - A request during an active overlay replaces the value and source and restarts the hold.
  - The hold counter decrements every cycle. When it reaches 0 with no new request, the arbiter returns to NONE on the next cycle. The overlay is therefore visible for exactly OVERLAY_CYCLES cycles.
  - Overlays run independently of the main FSM and survive i_start and i_stop.
- Output mux, registered:
  - Overlay active: o_hex = latched value, o_src = 1 or 2.
  - Otherwise: o_hex = seconds, o_src = 0.
  - o_hex reflects a state or counter change one cycle after it occurs. Latency from a request pulse to the overlay appearing on o_hex is 2 cycles.
- o_hex never exceeds MAX_SEC.

Optional Feature:
- Macro PAUSE_BLINK_EN.
- Defined: in PAUSE with no overlay active, o_blank toggles every TICK_CYCLES/2 cycles, using its own half-period counter.
  - Entering PAUSE starts the pattern with o_blank = 0.
  - Leaving PAUSE, or an overlay becoming active, forces o_blank 0 next cycle and resets the blink counter.
- Not defined: o_blank is tied to 0 and no blink counter is built.

Test Plan:
- Use TICK_CYCLES=4, OVERLAY_CYCLES=6, MAX_SEC=35 unless noted.
- Reset, then i_start pulse, RUN 12 cycles -> o_hex steps 0,1,2,3 at 4-cycle spacing, o_src=0.
- RUN to 35 -> o_done high exactly one cycle as o_hex becomes 35. A further 20 cycles hold 35. i_start -> o_hex 0 next-but-one cycle and counting resumes.
- At prescaler=2, assert i_pause for 10 cycles then release -> no seconds change while paused; next increment 2 cycles after release.
- i_vol_valid with i_vol=50 -> o_hex=35, o_src=2 for 6 cycles, then seconds readout. Simultaneous i_speed_valid (i_speed=7) and i_vol_valid -> o_hex=7, o_src=1. Re-request at hold=2 -> overlay extended a full 6 cycles.
- i_start and i_stop same cycle -> IDLE, o_hex 0. Assert i_rst_n low mid-RUN with overlay active -> all outputs 0 immediately, asynchronously.
- With PAUSE_BLINK_EN defined, pause 8 cycles -> o_blank pattern 0,0,1,1,0,0,1,1. Volume request during pause -> o_blank 0 while overlay shown.
